ifetch_unit: RTL and testbench
==============================

// Module: ifetch_unit
// PURPOSE
//  Instruction fetch stage feeding the RV64 instruction decoder. Holds the PC, issues one
//  word-fetch at a time to instruction memory over a valid/ready request + valid response
//  channel, and presents {instr, instr_pc} to decode with a valid/ready handshake.
//  Jumps, branches and traps redirect the PC; fetches already in flight are squashed.
// PARAMETERS
//  RESET_PC   64'h0000_0000_8000_0000   PC loaded on reset
// PORTS
//  clk              in   1   clock, all state on rising edge
//  rst              in   1   asynchronous reset, active-high
//  imem_req_valid   out  1   fetch request valid
//  imem_req_ready   in   1   memory accepts request this cycle
//  imem_req_addr    out  64  fetch address (= pc), word aligned
//  imem_rsp_valid   in   1   response valid; >=1 cycle after request acceptance
//  imem_rsp_data    in   32  fetched instruction word
//  redirect_valid   in   1   PC redirect from execute (jal/jalr/branch taken/trap)
//  redirect_pc      in   64  redirect target
//  instr_valid      out  1   instr/instr_pc valid to decoder
//  instr_ready      in   1   decoder/execute consumes instruction this cycle
//  instr            out  32  instruction word to decoder
//  instr_pc         out  64  PC of instr
//  fetch_fault      out  1   misaligned redirect target; fetching halted
// BEHAVIOUR
//  Reset (async assert): state=REQ, pc=RESET_PC, kill=0, instr=32'h0, instr_pc=RESET_PC,
//   instr_valid=0, fetch_fault=0. imem_req_valid=0 while rst is high; 1 in first cycle after.
//  Exactly one outstanding request. States:
//  REQ  : imem_req_valid=1, addr=pc. req_ready -> WAIT. Addr stable while valid except on
//         redirect: pc<=redirect_pc, stay REQ (redirect beats req_ready in same cycle:
//         request counted as NOT issued; memory must ignore it -> bench drives ready=0 then).
//  WAIT : no request. rsp_valid & ~kill & ~redirect -> instr<=rsp_data, instr_pc<=pc,
//         instr_valid<=1, HOLD. redirect (no rsp) -> pc<=redirect_pc, kill<=1, stay WAIT.
//         rsp_valid & (kill|redirect) -> drop data, kill<=0, pc<=redirect_pc if redirect, REQ.
//  HOLD : instr_valid=1, instr/instr_pc stable until taken. instr_ready & ~redirect ->
//         pc<=pc+4 (64-bit wrap), instr_valid<=0, REQ. redirect (with or without ready) ->
//         instr_valid<=0, pc<=redirect_pc, REQ; redirect wins over ready.
//  FAULT: entered from any state when redirect_valid & redirect_pc[1:0]!=0. fetch_fault=1,
//         instr_valid=0, imem_req_valid=0, pc<=redirect_pc. Pending response (from WAIT) is
//         dropped: kill<=1 if leaving WAIT without rsp. Aligned redirect -> pc<=target, REQ
//         (if kill still set, go WAIT-drain first: ignore rsp, then REQ). Only reset or
//         aligned redirect exits.
//  Latency: req accepted cycle N, rsp cycle N+k -> instr_valid cycle N+k+1. Redirect in
//   cycle N -> imem_req_valid with new addr in cycle N+1 (unless draining kill).
//  Peak throughput one instruction per 3 cycles with single-cycle memory.
//  instr_valid never asserts for a squashed fetch; fetch_fault and instr_valid exclusive.
// TESTING
//  1 Reset release, ready=1, rsp 1 cycle later = 32'h00000093 -> req addr 0x8000_0000;
//    instr_valid with instr=0x00000093, instr_pc=0x8000_0000; next req addr 0x8000_0004.
//  2 Decoder stalls instr_ready=0 for 5 cycles -> instr/instr_pc held, no new request,
//    imem_req_valid=0 throughout; ready=1 -> next req at pc+4.
//  3 Redirect to 0x8000_0100 while in WAIT, rsp arrives 3 cycles later = 0xDEADBEEF ->
//    0xDEADBEEF never presented; next req addr 0x8000_0100.
//  4 Redirect to 0x8000_0200 same cycle as instr_ready in HOLD -> instr dropped, next req
//    addr 0x8000_0200 (not pc+4).
//  5 Redirect to 0x8000_0102 -> fetch_fault=1, no requests for 10 cycles; redirect to
//    0x8000_0300 -> fault clears, req addr 0x8000_0300.
//  6 rst asserted mid-WAIT -> all outputs at reset values immediately; stale rsp after
//    release not presented; first req addr RESET_PC.

Source files
------------

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - RV64 instruction fetch stage: PC, single-outstanding imem fetch, decode handoff.
// Redirects squash in-flight fetches; a misaligned redirect target parks the unit in FAULT.
module ifetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [63:0] instr_pc,
  output logic        fetch_fault
);

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [63:0] r_pc;
  logic [63:0] w_pc_nxt;
  logic        r_kill;
  logic        w_kill_nxt;
  logic [31:0] r_instr;
  logic [31:0] w_instr_nxt;
  logic [63:0] r_instr_pc;
  logic [63:0] w_instr_pc_nxt;

  logic        w_redir_ok;
  logic        w_redir_bad;
  logic        w_kill_left;

  assign w_redir_ok  = redirect_valid & (redirect_pc[1:0] == 2'b00);
  assign w_redir_bad = redirect_valid & (redirect_pc[1:0] != 2'b00);
  // A killed fetch is still owed by memory until its response shows up.
  assign w_kill_left = r_kill & ~imem_rsp_valid;

  assign imem_req_valid = (r_state == ST_REQ) & ~rst;
  assign imem_req_addr  = r_pc;
  assign instr_valid    = (r_state == ST_HOLD);
  assign fetch_fault    = (r_state == ST_FAULT);
  assign instr          = r_instr;
  assign instr_pc       = r_instr_pc;

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_kill_nxt     = r_kill;
    w_instr_nxt    = r_instr;
    w_instr_pc_nxt = r_instr_pc;

    if (w_redir_bad) begin
      w_state_nxt = ST_FAULT;
      w_pc_nxt    = redirect_pc;
      if (r_state == ST_WAIT) begin
        w_kill_nxt = ~imem_rsp_valid;
      end else if (r_state == ST_FAULT) begin
        w_kill_nxt = w_kill_left;
      end
    end else begin
      case (r_state)
        ST_REQ: begin
          if (w_redir_ok) begin
            w_pc_nxt = redirect_pc;
          end else if (imem_req_ready) begin
            w_state_nxt = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_rsp_valid) begin
            if (r_kill | w_redir_ok) begin
              w_kill_nxt  = 1'b0;
              w_state_nxt = ST_REQ;
              if (w_redir_ok) begin
                w_pc_nxt = redirect_pc;
              end
            end else begin
              w_instr_nxt    = imem_rsp_data;
              w_instr_pc_nxt = r_pc;
              w_state_nxt    = ST_HOLD;
            end
          end else if (w_redir_ok) begin
            w_pc_nxt   = redirect_pc;
            w_kill_nxt = 1'b1;
          end
        end
        ST_HOLD: begin
          if (w_redir_ok) begin
            w_pc_nxt    = redirect_pc;
            w_state_nxt = ST_REQ;
          end else if (instr_ready) begin
            w_pc_nxt    = r_pc + 64'd4;
            w_state_nxt = ST_REQ;
          end
        end
        ST_FAULT: begin
          w_kill_nxt = w_kill_left;
          if (w_redir_ok) begin
            w_pc_nxt    = redirect_pc;
            w_state_nxt = w_kill_left ? ST_WAIT : ST_REQ;
          end
        end
        default: begin
          w_state_nxt = ST_REQ;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_REQ;
      r_pc       <= RESET_PC;
      r_kill     <= 1'b0;
      r_instr    <= 32'h0;
      r_instr_pc <= RESET_PC;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_kill     <= w_kill_nxt;
      r_instr    <= w_instr_nxt;
      r_instr_pc <= w_instr_pc_nxt;
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - directed and randomized checks of ifetch_unit against a PC-level model.
module tb_ifetch_unit;

  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic        fetch_fault;

  int n_chk  = 0;
  int n_fail = 0;

  ifetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .fetch_fault    (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0F0F;
  endfunction

  logic        mem_pend;
  logic [63:0] mem_addr;
  int          mem_cnt;
  logic [63:0] exp_pc;
  logic        exp_fault;
  logic        exp_req;
  logic        redir;
  logic [63:0] tgt;
  logic        was_pend;
  int          delivered;

  initial begin
    rst = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'h0;
    instr_ready    = 1'b0;

    // reset values
    #2;
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_fault", fetch_fault, 0);
    chk("rst_instr", instr, 0);
    chk("rst_instr_pc", instr_pc, RST_PC);

    // 1: first fetch
    @(negedge clk);
    rst = 1'b0;
    imem_req_ready = 1'b1;
    #1;
    chk("t1_req_valid", imem_req_valid, 1);
    chk("t1_req_addr", imem_req_addr, RST_PC);
    @(negedge clk);
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0000_0093;
    #1;
    chk("t1_wait_no_req", imem_req_valid, 0);
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    chk("t1_instr_valid", instr_valid, 1);
    chk("t1_instr", instr, 32'h0000_0093);
    chk("t1_instr_pc", instr_pc, RST_PC);

    // 2: decoder stall
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t2_hold_valid", instr_valid, 1);
      chk("t2_hold_instr", instr, 32'h0000_0093);
      chk("t2_hold_pc", instr_pc, RST_PC);
      chk("t2_no_req", imem_req_valid, 0);
    end
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    chk("t2_instr_gone", instr_valid, 0);
    chk("t2_req_valid", imem_req_valid, 1);
    chk("t2_req_addr", imem_req_addr, RST_PC + 64'd4);

    // 3: redirect while waiting, stale response squashed
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0100;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("t3_wait_no_req", imem_req_valid, 0);
    @(negedge clk);
    @(negedge clk);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    chk("t3_no_instr", instr_valid, 0);
    chk("t3_req_valid", imem_req_valid, 1);
    chk("t3_req_addr", imem_req_addr, 64'h8000_0100);
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0010_0093;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    chk("t3_instr", instr, 32'h0010_0093);
    chk("t3_instr_pc", instr_pc, 64'h8000_0100);

    // 4: redirect beats instr_ready in HOLD
    instr_ready    = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0200;
    @(negedge clk);
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    chk("t4_instr_gone", instr_valid, 0);
    chk("t4_req_addr", imem_req_addr, 64'h8000_0200);
    chk("t4_req_valid", imem_req_valid, 1);

    // 5: misaligned redirect faults, aligned one recovers
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0102;
    @(negedge clk);
    redirect_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("t5_fault", fetch_fault, 1);
      chk("t5_no_req", imem_req_valid, 0);
      chk("t5_no_instr", instr_valid, 0);
      @(negedge clk);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0300;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("t5_fault_clear", fetch_fault, 0);
    chk("t5_req_valid", imem_req_valid, 1);
    chk("t5_req_addr", imem_req_addr, 64'h8000_0300);

    // 6: reset mid-WAIT, stale response after release
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t6_req_valid", imem_req_valid, 0);
    chk("t6_instr_valid", instr_valid, 0);
    chk("t6_fault", fetch_fault, 0);
    chk("t6_instr", instr, 0);
    chk("t6_instr_pc", instr_pc, RST_PC);
    chk("t6_addr", imem_req_addr, RST_PC);
    @(negedge clk);
    rst = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0BAD_0BAD;
    #1;
    chk("t6_first_req", imem_req_valid, 1);
    chk("t6_first_addr", imem_req_addr, RST_PC);
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    chk("t6_stale_dropped", instr_valid, 0);
    chk("t6_still_req", imem_req_valid, 1);

    // randomized run against a PC-level model
    mem_pend  = 1'b0;
    mem_addr  = 64'h0;
    mem_cnt   = 0;
    exp_pc    = RST_PC;
    exp_fault = 1'b0;
    exp_req   = 1'b0;
    delivered = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      chk("r_fault", fetch_fault, exp_fault);
      if (instr_valid && fetch_fault) chk("r_exclusive", 1, 0);
      if (exp_fault) begin
        chk("r_fault_no_req", imem_req_valid, 0);
        chk("r_fault_no_instr", instr_valid, 0);
      end
      if (instr_valid) begin
        chk("r_instr_pc", instr_pc, exp_pc);
        chk("r_instr", instr, mem_word(exp_pc));
      end
      if (imem_req_valid) chk("r_req_addr", imem_req_addr, exp_pc);
      if (exp_req) chk("r_req_after_redirect", imem_req_valid, 1);

      redir = ($urandom % 12) == 0;
      case ($urandom % 8)
        0:       tgt = 64'hFFFF_FFFF_FFFF_FFF0 + 64'(($urandom % 4) * 4);
        1, 2:    tgt = 64'h8000_0000 + 64'(($urandom % 64) * 4) + 64'($urandom_range(1, 3));
        default: tgt = 64'h8000_0000 + 64'(($urandom % 64) * 4);
      endcase
      redirect_valid = redir;
      redirect_pc    = tgt;
      if (mem_pend && mem_cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(mem_addr);
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
      end
      imem_req_ready = redir ? 1'b0 : (($urandom % 4) != 0);
      instr_ready    = ($urandom % 3) != 0;

      was_pend = mem_pend;
      if (imem_rsp_valid) mem_pend = 1'b0;
      else if (mem_pend) mem_cnt--;
      if (imem_req_valid && imem_req_ready) begin
        chk("r_one_outstanding", was_pend, 0);
        mem_pend = 1'b1;
        mem_addr = imem_req_addr;
        mem_cnt  = $urandom % 4;
      end
      if (instr_valid && instr_ready && !redir) begin
        exp_pc = exp_pc + 64'd4;
        delivered++;
      end
      exp_req = 1'b0;
      if (redir) begin
        exp_pc    = tgt;
        exp_fault = (tgt[1:0] != 2'b00);
        exp_req   = !exp_fault && !mem_pend;
      end
      @(negedge clk);
    end
    chk("r_progress", delivered >= 100, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
